fpu_param: RTL and testbench
============================

Name: fpu_param

Overview:
- Parametrised successor to the team's single-precision add/mul FPU.
- Takes two IEEE-754-style operands of configurable exponent and mantissa width and performs add, subtract or multiply.
- Uses a start/done handshake, IEEE round-to-nearest-even with guard/round/sticky bits, special-value handling and status flags.
- Sits as a multi-cycle coprocessor behind the datapath's register file; one operation is in flight at a time.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width; hidden bit is implicit.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 add, 01 sub (A-B), 10 mul, 11 reserved.
- A  in  EXP_W+MAN_W+1  operand A, {sign, exp, frac}.
- B  in  EXP_W+MAN_W+1  operand B.
- R  out  EXP_W+MAN_W+1  result; holds until the next done.
- done  out  1  one-cycle pulse when R and flags are valid.
- busy  out  1  high from the cycle after start is accepted until done.
- overflow  out  1  result rounded to ±inf.
- underflow  out  1  result flushed to ±0.
- invalid  out  1  NaN produced (inf-inf, 0*inf, NaN input, op=11).

Behaviour:
- Reset: when rst is high at a clock edge, the FSM goes to IDLE and R, done, busy and all flags clear to 0. This applies mid-operation too; the operation is abandoned with no done.
- FSM states: IDLE -> UNPACK -> EXEC -> NORM -> ROUND -> DONE -> IDLE.
- IDLE: start=1 latches A, B and op internally; later input changes do not affect the result. start in any other state is ignored.
- UNPACK:
  - Exp=0 is treated as zero; denormals flush to zero.
  - Exp all-ones is inf or NaN.
  - Sub is executed as A + (-B).
  - Add path: swap so the larger-magnitude operand is first. Right-shift the smaller significand {1,frac,GRS=000} by the exponent difference, ORing shifted-out bits into sticky. Shifts ≥ MAN_W+3 leave sticky only.
  - Mul path: exponent = eA+eB-bias, computed signed in EXP_W+2 bits; sign = sA XOR sB.
- EXEC:
  - Add/sub: 1 cycle, (MAN_W+5)-bit add or subtract of magnitudes.
  - Mul: shift-add, one multiplier bit per cycle, MAN_W+1 cycles, producing a 2*(MAN_W+1)-bit product. Product bits below the GRS positions fold into sticky.
- NORM:
  - On carry-out or a product MSB at 2^1: shift right 1 (sticky preserved) and increment the exponent.
  - Otherwise: shift left by the leading-zero count and decrement the exponent.
  - An exact-zero sum gives +0.
- ROUND:
  - RNE: increment when G & (R | S | lsb).
  - A mantissa overflow from rounding renormalises with exponent+1.
  - Exponent ≥ all-ones: ±inf, overflow=1.
  - Exponent ≤ 0: ±0, underflow=1.
- DONE: R and flags register, done=1 for exactly this cycle, busy=0. The FSM returns to IDLE on the next edge. A start in the DONE cycle is ignored.
- Special cases bypass EXEC. They take the same latency as their op for a deterministic schedule.
  - NaN result is canonical {0, all-ones exp, 1, zeros}, with invalid=1.
  - inf ± finite = inf.
  - x*0 = signed 0.
- Latency, counted as edges from the start-accepting edge to done high:
  - add/sub: 5.
  - mul: MAN_W+5, which is 28 for the default parameters.

Test Plan:
- Add: A=0x3F800000, B=0x40000000, op=00 -> R=0x40400000, done 5 cycles after start, no flags, busy high for 4 cycles.
- Mul: A=0x3FC00000, B=0x40200000, op=10 -> R=0x40700000, done at cycle 28.
- Subtract/cancel: A=B=0x3F800000, op=01 -> R=0x00000000. Inf-inf: A=0x7F800000, B=0x7F800000, op=01 -> R=0x7FC00000, invalid=1.
- RNE:
  - 0x3F800000+0x33800000 -> 0x3F800000 (tie to even).
  - 0x3F800000+0x33C00000 -> 0x3F800001.
  - Overflow: 0x7F7FFFFF*0x40000000 -> 0x7F800000, overflow=1.
- Robustness:
  - start pulsed while busy, and A/B changed mid-op -> result unchanged, no second done.
  - rst asserted at mul cycle 10 -> R=0, done never pulses, next op runs normally.
- Parametrisation: EXP_W=5, MAN_W=10 (half precision), 0x3C00*0x4000 -> 0x4000, mul done at cycle 15.

Source files
------------

// File: rtl/fpu_param.sv
// Multi-cycle IEEE-style add/sub/mul with RNE rounding; one operation in flight, start sampled only in IDLE.
// Latency (edges, accepting edge included): add/sub 5, mul MAN_W+5; i_start is ignored while busy or in DONE.
module fpu_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [1:0]             i_op,
  input  logic [EXP_W+MAN_W:0]   i_a,
  input  logic [EXP_W+MAN_W:0]   i_b,
  output logic [EXP_W+MAN_W:0]   o_r,
  output logic                   o_done,
  output logic                   o_busy,
  output logic                   o_overflow,
  output logic                   o_underflow,
  output logic                   o_invalid
);

  localparam int W   = EXP_W + MAN_W + 1;
  localparam int SW  = MAN_W + 4;
  localparam int XW  = EXP_W + 2;
  localparam int N   = MAN_W + 1;
  localparam int CW  = $clog2(N + 1);
  localparam int LZW = $clog2(SW + 1);

  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [XW-1:0]    BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]      r_state;
  logic [W-1:0]    r_a, r_b;
  logic [1:0]      r_op;
  logic            r_mul, r_sign, r_esub, r_spec, r_spec_inv, r_zero;
  logic [W-1:0]    r_spec_res;
  logic [XW-1:0]   r_exp;
  logic [SW-1:0]   r_big, r_small;
  logic [N-1:0]    r_mcand, r_mplier;
  logic [2*N-1:0]  r_prod;
  logic [CW-1:0]   r_cnt;
  logic [SW:0]     r_man;

  logic             w_sa, w_sb, w_sbe, w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_a_ge;
  logic [EXP_W-1:0] w_ea, w_eb, w_ebig, w_esml, w_d;
  logic [MAN_W-1:0] w_fa, w_fb, w_fbig, w_fsml;
  logic [SW-1:0]    w_ssml, w_shifted, w_aligned;
  logic             w_lost;
  logic [XW-1:0]    w_mexp;
  logic             w_spec, w_spec_inv;
  logic [W-1:0]     w_spec_res;

  assign w_sa  = r_a[W-1];
  assign w_ea  = r_a[W-2:MAN_W];
  assign w_fa  = r_a[MAN_W-1:0];
  assign w_sb  = r_b[W-1];
  assign w_eb  = r_b[W-2:MAN_W];
  assign w_fb  = r_b[MAN_W-1:0];
  assign w_sbe = w_sb ^ (r_op == 2'b01);
  assign w_za  = (w_ea == '0);
  assign w_zb  = (w_eb == '0);
  assign w_ia  = (w_ea == EMAX) && (w_fa == '0);
  assign w_ib  = (w_eb == EMAX) && (w_fb == '0);
  assign w_na  = (w_ea == EMAX) && (w_fa != '0);
  assign w_nb  = (w_eb == EMAX) && (w_fb != '0);

  assign w_a_ge = (r_a[W-2:0] >= r_b[W-2:0]);
  assign w_ebig = w_a_ge ? w_ea : w_eb;
  assign w_esml = w_a_ge ? w_eb : w_ea;
  assign w_fbig = w_a_ge ? w_fa : w_fb;
  assign w_fsml = w_a_ge ? w_fb : w_fa;
  assign w_d    = w_ebig - w_esml;
  assign w_ssml = {1'b1, w_fsml, 3'b000};
  assign w_mexp = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;

  // Alignment shift of the smaller operand; everything shifted out lands in sticky.
  always_comb begin
    w_shifted = '0;
    w_lost    = 1'b0;
    if (int'(w_d) >= MAN_W + 3) begin
      w_aligned = SW'(1);
    end else begin
      w_shifted = w_ssml >> w_d;
      w_lost    = |(w_ssml & ~({SW{1'b1}} << w_d));
      w_aligned = {w_shifted[SW-1:1], w_shifted[0] | w_lost};
    end
  end

  always_comb begin
    w_spec     = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_res = '0;
    if (r_op == 2'b11 || w_na || w_nb) begin
      w_spec_res = QNAN;
      w_spec_inv = 1'b1;
    end else if (r_op == 2'b10) begin
      if ((w_ia && w_zb) || (w_za && w_ib)) begin
        w_spec_res = QNAN;
        w_spec_inv = 1'b1;
      end else if (w_ia || w_ib) w_spec_res = {w_sa ^ w_sb, EMAX, {MAN_W{1'b0}}};
      else if (w_za || w_zb)     w_spec_res = {w_sa ^ w_sb, {(W-1){1'b0}}};
      else                       w_spec     = 1'b0;
    end else begin
      if (w_ia && w_ib && (w_sa != w_sbe)) begin
        w_spec_res = QNAN;
        w_spec_inv = 1'b1;
      end else if (w_ia)         w_spec_res = {w_sa, EMAX, {MAN_W{1'b0}}};
      else if (w_ib)             w_spec_res = {w_sbe, EMAX, {MAN_W{1'b0}}};
      else if (w_za && w_zb)     w_spec_res = {w_sa & w_sbe, {(W-1){1'b0}}};
      else if (w_za)             w_spec_res = {w_sbe, r_b[W-2:0]};
      else if (w_zb)             w_spec_res = r_a;
      else                       w_spec     = 1'b0;
    end
  end

  logic [N:0]     w_pacc;
  logic [SW:0]    w_nin;
  logic [LZW-1:0] w_lz;
  logic           w_lz_found;

  assign w_pacc = {1'b0, r_prod[2*N-1:N]} + {1'b0, (r_mplier[0] ? r_mcand : {N{1'b0}})};
  // Product bits map onto the sum layout: {2^1, 2^0, fraction, G, R} plus folded sticky.
  assign w_nin  = r_mul ? {r_prod[2*N-1:MAN_W-2], |r_prod[MAN_W-3:0]} : r_man;

  always_comb begin
    w_lz       = '0;
    w_lz_found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!w_lz_found && w_nin[i]) begin
        w_lz       = LZW'(SW - 1 - i);
        w_lz_found = 1'b1;
      end
    end
  end

  logic             w_inc, w_ovf, w_unf, w_inv;
  logic [MAN_W+1:0] w_rsig;
  logic [XW-1:0]    w_rexp;
  logic [MAN_W-1:0] w_rfrac;
  logic [W-1:0]     w_res;

  assign w_inc   = r_man[2] & (r_man[1] | r_man[0] | r_man[3]);
  assign w_rsig  = {1'b0, r_man[SW-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};
  assign w_rexp  = r_exp + {{(XW-1){1'b0}}, w_rsig[MAN_W+1]};
  assign w_rfrac = w_rsig[MAN_W+1] ? w_rsig[MAN_W:1] : w_rsig[MAN_W-1:0];

  always_comb begin
    w_res = {r_sign, w_rexp[EXP_W-1:0], w_rfrac};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    if (r_spec) begin
      w_res = r_spec_res;
      w_inv = r_spec_inv;
    end else if (r_zero) begin
      w_res = '0;
    end else if (!w_rexp[XW-1] && (w_rexp >= {2'b00, EMAX})) begin
      w_res = {r_sign, EMAX, {MAN_W{1'b0}}};
      w_ovf = 1'b1;
    end else if (w_rexp[XW-1] || (w_rexp == '0)) begin
      w_res = {r_sign, {(W-1){1'b0}}};
      w_unf = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a <= '0; r_b <= '0; r_op <= '0;
      r_mul <= 1'b0; r_sign <= 1'b0; r_esub <= 1'b0; r_zero <= 1'b0;
      r_spec <= 1'b0; r_spec_inv <= 1'b0; r_spec_res <= '0;
      r_exp <= '0; r_big <= '0; r_small <= '0; r_man <= '0;
      r_mcand <= '0; r_mplier <= '0; r_prod <= '0; r_cnt <= '0;
      o_r <= '0; o_done <= 1'b0; o_busy <= 1'b0;
      o_overflow <= 1'b0; o_underflow <= 1'b0; o_invalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_a     <= i_a;
          r_b     <= i_b;
          r_op    <= i_op;
          o_busy  <= 1'b1;
          r_state <= S_UNPACK;
        end
        S_UNPACK: begin
          r_spec     <= w_spec;
          r_spec_inv <= w_spec_inv;
          r_spec_res <= w_spec_res;
          r_mul      <= (r_op == 2'b10);
          r_esub     <= (w_sa != w_sbe);
          r_big      <= {1'b1, w_fbig, 3'b000};
          r_small    <= w_aligned;
          r_mcand    <= {1'b1, w_fa};
          r_mplier   <= {1'b1, w_fb};
          r_prod     <= '0;
          r_cnt      <= '0;
          if (r_op == 2'b10) begin
            r_sign <= w_sa ^ w_sb;
            r_exp  <= w_mexp;
          end else begin
            r_sign <= w_a_ge ? w_sa : w_sbe;
            r_exp  <= {2'b00, w_ebig};
          end
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (!r_mul) begin
            r_man   <= r_esub ? ({1'b0, r_big} - {1'b0, r_small}) : ({1'b0, r_big} + {1'b0, r_small});
            r_state <= S_NORM;
          end else begin
            r_prod   <= {w_pacc, r_prod[N-1:1]};
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == CW'(N - 1)) r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_zero <= (w_nin == '0);
          if (w_nin[SW]) begin
            r_man <= {1'b0, w_nin[SW:2], w_nin[1] | w_nin[0]};
            r_exp <= r_exp + XW'(1);
          end else begin
            r_man <= w_nin << w_lz;
            r_exp <= r_exp - XW'(w_lz);
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          o_r         <= w_res;
          o_overflow  <= w_ovf;
          o_underflow <= w_unf;
          o_invalid   <= w_inv;
          o_done      <= 1'b1;
          o_busy      <= 1'b0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_param.sv
// Vector-table and scoreboard bench for fpu_param at single and half precision.
module tb_fpu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, h_start, sel;
  logic [1:0]  op, h_op;
  logic [31:0] a, b, f_r;
  logic [15:0] h_a, h_b, h_r;
  logic        f_done, f_busy, f_ovf, f_unf, f_inv;
  logic        h_done, h_busy, h_ovf, h_unf, h_inv;

  fpu_param #(.EXP_W(8), .MAN_W(23)) u_sp (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .o_r(f_r), .o_done(f_done), .o_busy(f_busy),
    .o_overflow(f_ovf), .o_underflow(f_unf), .o_invalid(f_inv)
  );

  fpu_param #(.EXP_W(5), .MAN_W(10)) u_hp (
    .i_clk(clk), .i_rst(rst), .i_start(h_start), .i_op(h_op), .i_a(h_a), .i_b(h_b),
    .o_r(h_r), .o_done(h_done), .o_busy(h_busy),
    .o_overflow(h_ovf), .o_underflow(h_unf), .o_invalid(h_inv)
  );

  logic [31:0] cur_r;
  logic [2:0]  cur_fl;
  logic        cur_done, cur_busy;
  assign cur_r    = sel ? {16'h0, h_r} : f_r;
  assign cur_fl   = sel ? {h_ovf, h_unf, h_inv} : {f_ovf, f_unf, f_inv};
  assign cur_done = sel ? h_done : f_done;
  assign cur_busy = sel ? h_busy : f_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  always @(negedge clk) if (f_done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  fl;   // {overflow, underflow, invalid}
    int          lat;
  } vec_t;
  vec_t vecs[18];

  logic [31:0] q_r[$];
  logic [2:0]  q_f[$];
  int          q_lat[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic run_op(input logic hs, input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic [2:0] ef, input int el, input string nm);
    int lat, bc, xl;
    logic [31:0] xr;
    logic [2:0]  xf;
    q_r.push_back(er); q_f.push_back(ef); q_lat.push_back(el);
    sel = hs;
    if (hs) begin h_start = 1'b1; h_op = o; h_a = av[15:0]; h_b = bv[15:0]; end
    else    begin start = 1'b1; op = o; a = av; b = bv; end
    @(posedge clk); #1;
    start = 1'b0; h_start = 1'b0;
    lat = 1; bc = 0;
    while (!cur_done && lat < 100) begin
      if (cur_busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    xr = q_r.pop_front(); xf = q_f.pop_front(); xl = q_lat.pop_front();
    if (!cur_done) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: no done after %0d cycles, required %0d", nm, lat, xl);
    end else begin
      chk({nm, " R"}, cur_r, xr);
      chk({nm, " flags"}, {29'b0, cur_fl}, {29'b0, xf});
      chk({nm, " latency"}, 32'(lat), 32'(xl));
      chk({nm, " busy cycles"}, 32'(bc), 32'(xl - 1));
      chk({nm, " busy at done"}, {31'b0, cur_busy}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, d0;
    vecs[0]  = '{2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000, 5};
    vecs[1]  = '{2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000, 5};
    vecs[2]  = '{2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b001, 5};
    vecs[3]  = '{2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000, 5};
    vecs[4]  = '{2'b00, 32'h3F800000, 32'h33C00000, 32'h3F800001, 3'b000, 5};
    vecs[5]  = '{2'b10, 32'h3FC00000, 32'h40200000, 32'h40700000, 3'b000, 28};
    vecs[6]  = '{2'b10, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b100, 28};
    vecs[7]  = '{2'b01, 32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 5};
    vecs[8]  = '{2'b00, 32'hBF800000, 32'h3F000000, 32'hBF000000, 3'b000, 5};
    vecs[9]  = '{2'b10, 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 28};
    vecs[10] = '{2'b10, 32'h3F800000, 32'h00000000, 32'h00000000, 3'b000, 28};
    vecs[11] = '{2'b10, 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 28};
    vecs[12] = '{2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000, 5};
    vecs[13] = '{2'b00, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b001, 5};
    vecs[14] = '{2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 3'b010, 28};
    vecs[15] = '{2'b11, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 3'b001, 5};
    vecs[16] = '{2'b00, 32'h3F7FFFFF, 32'h33800000, 32'h3F800000, 3'b000, 5};
    vecs[17] = '{2'b00, 32'h3F7FFFFF, 32'h33000000, 32'h3F800000, 3'b000, 5};

    rst = 1'b1; start = 1'b0; h_start = 1'b0; sel = 1'b0;
    op = 2'b00; h_op = 2'b00; a = '0; b = '0; h_a = '0; h_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset R", f_r, 32'h0);
    chk("reset done/busy", {30'b0, f_done, f_busy}, 32'h0);
    chk("reset flags", {29'b0, f_ovf, f_unf, f_inv}, 32'h0);
    chk("reset half R", {16'h0, h_r}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++)
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].fl, vecs[i].lat,
             $sformatf("vec%0d", i));

    run_op(1'b1, 2'b10, 32'h3C00, 32'h4000, 32'h4000, 3'b000, 15, "half mul");
    run_op(1'b1, 2'b00, 32'h3C00, 32'h4000, 32'h4200, 3'b000, 5, "half add");

    // Start pulses while busy and in DONE, operands changed mid-flight.
    sel = 1'b0;
    d0 = done_cnt;
    start = 1'b1; op = 2'b00; a = 32'h3F800000; b = 32'h40000000;
    @(posedge clk); #1;
    start = 1'b0;
    a = 32'h12345678; b = 32'h40A00000; op = 2'b10;
    lat = 1;
    while (!f_done && lat < 100) begin
      start = (lat == 2);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("midop R", f_r, 32'h40400000);
    chk("midop latency", 32'(lat), 32'd5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("midop done count", 32'(done_cnt - d0), 32'd1);
    chk("midop idle busy", {31'b0, f_busy}, 32'd0);

    // Reset during a multiply.
    start = 1'b1; op = 2'b10; a = 32'h3FC00000; b = 32'h40200000;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset R", f_r, 32'h0);
    chk("midreset done/busy", {30'b0, f_done, f_busy}, 32'h0);
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk("midreset no done", 32'(done_cnt - d0), 32'd0);
    run_op(1'b0, 2'b10, 32'h3FC00000, 32'h40200000, 32'h40700000, 3'b000, 28, "post reset mul");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
